shift_add_mult: RTL and testbench

//   Sequential unsigned integer multiplier using the shift-and-add algorithm,
//   one partial product per clock.
//   A start request latches operands A and B. After WIDTH iteration cycles the
//   2*WIDTH-bit product is presented and done is raised.

---
 rtl/shift_add_mult.sv | 140 ++++++++++++++
 tb/tb_shift_add_mult.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
//
// A rising edge on start latches A and B, unless a multiply is already
// running. WIDTH clocks later the 2*WIDTH-bit product is presented and done
// rises. done then stays high until the next start is accepted. product
// changes only when a multiply completes, so it holds the previous result
// while a new multiply is running.
//
// Ports:
//   clk      in   1          system clock, rising edge
//   rst      in   1          asynchronous, active-high reset
//   start    in   1          start request (level; only its rising edge acts)
//   A        in   WIDTH      multiplicand, unsigned, sampled at accept
//   B        in   WIDTH      multiplier, unsigned, sampled at accept
//   done     out  1          result valid, held until next accepted start
//   product  out  2*WIDTH    A*B, unsigned, registered
module shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  // Iteration counter only needs to reach WIDTH-1
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            start_q;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   count;

  logic            accept_c;
  logic            last_c;
  logic            load_c;
  logic            step_c;
  logic            finish_c;
  logic [PW-1:0]   sum_c;

  // Start edge detector; a held level never retriggers, starts while busy are dropped
  assign accept_c = start & ~start_q & (state != S_BUSY);
  assign last_c   = (count == CW'(WIDTH - 1));

  // Accumulator value after this iteration's conditional add
  assign sum_c = acc + (mplier[0] ? mcand : PW'(0));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept_c) state_nxt = S_BUSY;
      S_BUSY: if (last_c)   state_nxt = S_DONE;
      S_DONE: if (accept_c) state_nxt = S_BUSY;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // Datapath controls decoded from state
  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    unique case (state)
      S_IDLE: load_c = accept_c;
      S_BUSY: begin
        step_c   = 1'b1;
        finish_c = last_c;
      end
      S_DONE: load_c = accept_c;
      default: ;
    endcase
  end

  // Start history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // Operand shifters, accumulator and iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load_c) begin
      mcand  <= PW'(A);
      mplier <= B;
      acc    <= '0;
      count  <= '0;
    end else if (step_c) begin
      acc    <= sum_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

  // Result registers: product updates only on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      product <= '0;
    end else if (load_c) begin
      done    <= 1'b0;
    end else if (finish_c) begin
      done    <= 1'b1;
      product <= sum_c;
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
module tb_shift_add_mult;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           done;
  logic [2*W-1:0] product;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc_cyc;
  } exp_t;

  exp_t           sb[$];
  int             cyc = 0;
  int             n_checks = 0;
  int             n_fail = 0;
  int             last_acc = -1000;
  logic [2*W-1:0] held = '0;
  logic           done_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: an accepted start at edge e yields a*b with done exactly W edges later
  function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'(int'(a) * int'(b));
  endfunction

  function automatic bit busy_at(input int e);
    return (last_acc < e) && (e <= last_acc + W);
  endfunction

  // Monitor: compares DUT outputs against the scoreboard every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && cyc >= sb[0].acc_cyc) begin
        if (cyc < sb[0].acc_cyc + W) begin
          check("done_low_busy", 32'(done), 32'd0);
          check("product_held_busy", 32'(product), 32'(held));
        end else begin
          check("done_at_latency", 32'(done), 32'd1);
          check("product", 32'(product), 32'(sb[0].prod));
          held     = sb[0].prod;
          done_exp = 1'b1;
          void'(sb.pop_front());
        end
      end else begin
        check("done_steady", 32'(done), 32'(done_exp));
        check("product_steady", 32'(product), 32'(held));
      end
    end
  end

  // Raise start for len cycles; queue the expected result if it will be accepted
  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b, input int len,
                       input bit scramble);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    if (start == 1'b0 && !busy_at(cyc + 1)) begin
      e.prod    = ref_mult(a, b);
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      last_acc  = cyc + 1;
    end
    start = 1'b1;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      if (scramble) begin
        A = W'($urandom);
        B = W'($urandom);
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      A = W'($urandom);
      B = W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #3;
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 7*7 with start held 5 cycles
    pulse(8'd7, 8'd7, 5, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    // Extremes
    pulse(8'd255, 8'd255, 1, 1'b1);
    wait_idle();
    pulse(8'd1, 8'd200, 1, 1'b0);
    wait_idle();

    // Zero multiplier still takes the full latency
    pulse(8'hAB, 8'd0, 2, 1'b0);
    wait_idle();
    pulse(8'd0, 8'd0, 1, 1'b0);
    wait_idle();

    // Start held through done must not retrigger, then a fresh pulse
    pulse(8'd20, 8'd11, 20, 1'b0);
    pulse(8'd3, 8'd5, 1, 1'b0);
    wait_idle();

    // Asynchronous reset mid-operation
    pulse(8'd12, 8'd10, 1, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_product", 32'(product), 32'd0);
    sb.delete();
    held     = '0;
    done_exp = 1'b0;
    last_acc = -1000;
    start    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulse(8'd12, 8'd10, 1, 1'b0);
    wait_idle();

    // Start during BUSY is ignored (not queued by the model)
    pulse(8'd100, 8'd200, 1, 1'b1);
    pulse(8'd9, 8'd9, 1, 1'b1);
    wait_idle();

    // Randomized traffic with mixed gaps, start lengths and mid-flight operand changes
    for (int i = 0; i < 60; i++) begin
      pulse(W'($urandom), W'($urandom), int'($urandom_range(1, 4)), 1'b1);
      repeat (int'($urandom_range(0, 10))) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
